karatsuba_mul_pipe: RTL and testbench

//  Pipelined, parametrised one-level Karatsuba multiplier with valid/ready handshake.

---
 rtl/kmul_pkg.sv | 22 ++
 rtl/kmul_pipe_reg.sv | 36 +++
 rtl/karatsuba_mul_pipe.sv | 160 ++++++++++++++++
 tb/tb_karatsuba_mul_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmul_pkg.sv
// Shared definitions for the pipelined Karatsuba multiplier.
// Latency: pure definitions, no logic of its own.
// Backpressure: not applicable.
package kmul_pkg;

    // Register stages between input handshake and result.
    localparam int KMUL_LATENCY = 3;

    // Widest operand the magnitude helper can handle.
    localparam int KMUL_MAX_N = 64;

    // Two's-complement magnitude of x when is_neg is set; identity otherwise.
    // Callers zero-extend an N-bit operand and keep the low N bits of the
    // result, so -2^(N-1) comes back as 2^(N-1).
    function automatic logic [KMUL_MAX_N-1:0] kmul_abs(
        input logic [KMUL_MAX_N-1:0] x,
        input logic                  is_neg
    );
        return is_neg ? -x : x;
    endfunction

endpackage

// File: rtl/kmul_pipe_reg.sv
// Generic pipeline register slice with a valid bit (load / hold / clear).
// Latency: 1 cycle from in_v to v.
// Backpressure: loads when empty or when the next stage loads; holds otherwise.
module kmul_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         in_v,
    input  logic [W-1:0] in_dat,
    input  logic         nxt_load,
    output logic         v,
    output logic [W-1:0] dat,
    output logic         load
);

    // A slot is free when empty, or when its occupant moves on this edge.
    assign load = ~v | nxt_load;

    // Valid bit follows the load; clear drops validity but leaves data stale.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v   <= 1'b0;
            dat <= '0;
        end else if (clear_i) begin
            v   <= 1'b0;
        end else if (load) begin
            v <= in_v;
            if (in_v) begin
                dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/karatsuba_mul_pipe.sv
// One-level Karatsuba N x N multiplier, signed/unsigned per beat, with tag sideband.
// Latency: 3 cycles from input handshake to out_valid_o; one result per cycle.
// Backpressure: up to 3 beats buffered; in_ready_o drops when the pipe is full or clear_i is high.
module karatsuba_mul_pipe #(
    parameter int N     = 32,
    parameter int TAG_W = 4,
    parameter int M     = 2*N
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     num1_i,
    input  logic [N-1:0]     num2_i,
    input  logic             signed_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [M-1:0]     resul_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [1:0]       occ_o
);
    import kmul_pkg::*;

    localparam int H = N / 2;

    if ((N % 2) != 0 || N < 4 || N > KMUL_MAX_N) begin : g_bad_n
        $error("karatsuba_mul_pipe: N must be even, >= 4 and <= %0d", KMUL_MAX_N);
    end
    if (M != 2*N) begin : g_bad_m
        $error("karatsuba_mul_pipe: M is derived as 2*N and must not be overridden");
    end

    // Control carried with every transaction.
    typedef struct packed {
        logic             neg;
        logic [TAG_W-1:0] tag;
    } kmul_ctl_t;

    typedef struct packed {
        kmul_ctl_t    ctl;
        logic [N-1:0] p;     // a_hi * b_hi
        logic [N-1:0] q;     // a_lo * b_lo
        logic [H:0]   r;     // a_hi + a_lo
        logic [H:0]   s;     // b_hi + b_lo
    } s1_t;

    typedef struct packed {
        kmul_ctl_t    ctl;
        logic [N-1:0] p;
        logic [N-1:0] q;
        logic [N:0]   mid;   // a_hi*b_lo + a_lo*b_hi
    } s2_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [M-1:0]     res;
    } s3_t;

    logic         v1, v2, v3;
    logic         ld1, ld2, ld3;
    s1_t          s1_d, s1_q;
    s2_t          s2_d, s2_q;
    s3_t          s3_d, s3_q;

    logic         a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;
    logic [H-1:0] a_hi, a_lo, b_hi, b_lo;
    logic [N+1:0] t;
    logic [N:0]   u;
    logic [M-1:0] mag;

    // Stage 1 inputs: operand magnitudes split into halves.
    assign a_neg = signed_i & num1_i[N-1];
    assign b_neg = signed_i & num2_i[N-1];
    assign a_mag = N'(kmul_abs(KMUL_MAX_N'(num1_i), a_neg));
    assign b_mag = N'(kmul_abs(KMUL_MAX_N'(num2_i), b_neg));
    assign a_hi  = a_mag[N-1:H];
    assign a_lo  = a_mag[H-1:0];
    assign b_hi  = b_mag[N-1:H];
    assign b_lo  = b_mag[H-1:0];

    // Stage 1 payload: the three half-width partial operands.
    always_comb begin
        s1_d         = '0;
        s1_d.ctl.neg = a_neg ^ b_neg;
        s1_d.ctl.tag = tag_i;
        s1_d.p       = N'(a_hi) * N'(b_hi);
        s1_d.q       = N'(a_lo) * N'(b_lo);
        s1_d.r       = (H+1)'(a_hi) + (H+1)'(a_lo);
        s1_d.s       = (H+1)'(b_hi) + (H+1)'(b_lo);
    end

    // Stage 2 inputs: middle term recovered as (r*s) - (p+q), never negative.
    assign t = (N+2)'(s1_q.r) * (N+2)'(s1_q.s);
    assign u = (N+1)'(s1_q.p) + (N+1)'(s1_q.q);

    // Stage 2 payload: outer products plus the middle term.
    always_comb begin
        s2_d     = '0;
        s2_d.ctl = s1_q.ctl;
        s2_d.p   = s1_q.p;
        s2_d.q   = s1_q.q;
        s2_d.mid = (N+1)'(t - (N+2)'(u));
    end

    // Stage 3 inputs: recombine and reapply the sign.
    assign mag = (M'(s2_q.p) << N) + (M'(s2_q.mid) << H) + M'(s2_q.q);

    // Stage 3 payload: final product and tag.
    always_comb begin
        s3_d     = '0;
        s3_d.tag = s2_q.ctl.tag;
        s3_d.res = s2_q.ctl.neg ? -mag : mag;
    end

    kmul_pipe_reg #(.W($bits(s1_t))) u_s1 (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .in_v     (in_valid_i),
        .in_dat   (s1_d),
        .nxt_load (ld2),
        .v        (v1),
        .dat      (s1_q),
        .load     (ld1)
    );

    kmul_pipe_reg #(.W($bits(s2_t))) u_s2 (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .in_v     (v1),
        .in_dat   (s2_d),
        .nxt_load (ld3),
        .v        (v2),
        .dat      (s2_q),
        .load     (ld2)
    );

    kmul_pipe_reg #(.W($bits(s3_t))) u_s3 (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .in_v     (v2),
        .in_dat   (s3_d),
        .nxt_load (out_ready_i),
        .v        (v3),
        .dat      (s3_q),
        .load     (ld3)
    );

    assign in_ready_o  = ~clear_i & ld1;
    assign out_valid_o = v3;
    assign resul_o     = s3_q.res;
    assign tag_o       = s3_q.tag;
    assign occ_o       = 2'(v1) + 2'(v2) + 2'(v3);

endmodule

// File: tb/tb_karatsuba_mul_pipe.sv
module tb_karatsuba_mul_pipe;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        clear     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic        sgn       = 1'b0;
    logic [31:0] num1      = '0;
    logic [31:0] num2      = '0;
    logic [3:0]  tag       = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] resul;
    logic [3:0]  tag_out;
    logic [1:0]  occ;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  tag;
    } exp_t;

    exp_t        q[$];
    logic        hold_vld = 1'b0;
    logic [63:0] held_res;
    logic [3:0]  held_tag;

    karatsuba_mul_pipe #(.N(32), .TAG_W(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .num1_i      (num1),
        .num2_i      (num2),
        .signed_i    (sgn),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .resul_o     (resul),
        .tag_o       (tag_out),
        .occ_o       (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Exact product as plain integer arithmetic, modulo 2^64.
    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic sg);
        longint sa, sb;
        if (sg) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Scoreboard: every accepted beat must come out once, in order, with its product.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold_vld = 1'b0;
        end else begin
            chk("occ_vs_inflight", 64'(occ), 64'(q.size()));
            if (hold_vld) begin
                chk("stall_valid_held", 64'(out_valid), 64'd1);
                chk("stall_res_held", resul, held_res);
                chk("stall_tag_held", 64'(tag_out), 64'(held_tag));
            end
            hold_vld = out_valid && !out_ready && !clear;
            held_res = resul;
            held_tag = tag_out;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    chk("sb_res", resul, q[0].res);
                    chk("sb_tag", 64'(tag_out), 64'(q[0].tag));
                    void'(q.pop_front());
                end
            end
            if (clear) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                q.push_back('{res: golden(num1, num2, sgn), tag: tag});
            end
        end
    end

    task automatic set_beat(input logic [31:0] a, input logic [31:0] b, input logic sg,
                            input logic [3:0] tg);
        num1 = a;
        num2 = b;
        sgn  = sg;
        tag  = tg;
    endtask

    // Single beat into an empty pipe; checks latency and a hand-computed product.
    task automatic issue1(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [3:0] tg, input logic [63:0] exp_res);
        int n;
        @(posedge clk); #1;
        set_beat(a, b, sg, tg);
        in_valid = 1'b1;
        #1 chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd3);
        chk({nm, "_res"}, resul, exp_res);
        chk({nm, "_tag"}, 64'(tag_out), 64'(tg));
    endtask

    initial begin
        int nvld, first, last, idx, guard;
        logic [31:0] ba[4];
        logic [31:0] bb[4];

        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_resul", resul, 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        @(negedge clk); @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed products
        issue1("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd5, 64'hFFFF_FFFE_0000_0001);
        issue1("s_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd1, 64'h0000_0000_0000_0001);
        issue1("s_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 4'd2, 64'h4000_0000_0000_0000);
        issue1("s_m2x3", 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        issue1("s_0xm7", 32'h0000_0000, 32'hFFFF_FFF9, 1'b1, 4'd4, 64'h0);
        issue1("u_mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 4'd9, 64'h0B00_EA4E_242D_2080);

        // Back-to-back random beats: one result per cycle, contiguous
        nvld = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 10) begin
                set_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(cyc));
                in_valid = 1'b1;
                #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                nvld++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        chk("b2b_count", 64'(nvld), 64'd10);
        chk("b2b_contig", 64'(last - first + 1), 64'd10);

        // Backpressure: 4 beats offered with the consumer stalled for 6 cycles
        ba = '{32'h0000_0007, 32'hFFFF_FFF0, 32'h0001_0000, 32'hDEAD_BEEF};
        bb = '{32'h0000_0009, 32'h0000_0010, 32'h0001_0000, 32'h1234_5678};
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            set_beat(ba[idx], bb[idx], 1'(idx % 2), 4'(8 + idx));
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                @(posedge clk); #1;
                idx++;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("bp_accepted", 64'(idx), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_occ", 64'(occ), 64'd3);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_head_res", resul, 64'd63);
        out_ready = 1'b1;
        guard = 0;
        while (idx < 4 && guard < 20) begin
            set_beat(ba[idx], bb[idx], 1'(idx % 2), 4'(8 + idx));
            in_valid = 1'b1;
            #1;
            if (in_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("bp_fourth_accepted", 64'(idx), 64'd4);
        guard = 0;
        while (occ != 2'd0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("bp_drained", 64'(occ), 64'd0);

        // Clear with two in flight and a beat offered at the same time
        out_ready = 1'b0;
        set_beat(32'd11, 32'd13, 1'b0, 4'd6);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_beat(32'd17, 32'd19, 1'b0, 4'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("clr_occ_before", 64'(occ), 64'd2);
        clear = 1'b1;
        in_valid = 1'b1;
        set_beat(32'd23, 32'd29, 1'b0, 4'd15);
        #1 chk("clr_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("clr_occ_after", 64'(occ), 64'd0);
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("clr_no_leak", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            set_beat($urandom, $urandom, 1'b0, 4'(i));
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_resul", resul, 64'd0);
        chk("arst_tag", 64'(tag_out), 64'd0);
        chk("arst_occ", 64'(occ), 64'd0);
        @(negedge clk); @(negedge clk); #2;
        rst_n = 1'b1;
        issue1("post_arst", 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 4'd12, 64'hFFFF_FFFF_FFFF_F000);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
